// File: rtl/register_file.sv
// Two-read/one-write register file with entry 0 hardwired to zero and a post-reset clear sequencer.
// Optional write-through bypass on the read ports: define REGISTER_FILE_BYPASS_EN.
module register_file #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 6
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [ADDRESS_WIDTH-1:0] register_file_read_address_1,
  input  logic [ADDRESS_WIDTH-1:0] register_file_read_address_2,
  input  logic [ADDRESS_WIDTH-1:0] register_file_write_address,
  input  logic [DATA_WIDTH-1:0]    register_file_write_value,
  input  logic                     register_file_write_enable,
  output logic [DATA_WIDTH-1:0]    register_file_read_value_1,
  output logic [DATA_WIDTH-1:0]    register_file_read_value_2,
  output logic                     busy
);

  localparam int unsigned DEPTH = 2 ** ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] LAST_INDEX = '1;

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] clear_index_q, clear_index_d;
  logic [DATA_WIDTH-1:0]    entries_q [1:DEPTH-1];

  logic                     mem_write_enable;
  logic [ADDRESS_WIDTH-1:0] mem_write_address;
  logic [DATA_WIDTH-1:0]    mem_write_data;
  logic                     user_write;

  assign user_write = register_file_write_enable && (register_file_write_address != '0);

  always_comb begin
    state_d           = state_q;
    clear_index_d     = clear_index_q;
    mem_write_enable  = 1'b0;
    mem_write_address = register_file_write_address;
    mem_write_data    = register_file_write_value;
    if (reset) begin
      state_d       = CLEAR;
      clear_index_d = ADDRESS_WIDTH'(1);
    end else begin
      unique case (state_q)
        CLEAR: begin
          // Sequencer owns the write port; the user strobe is dropped here.
          mem_write_enable  = 1'b1;
          mem_write_address = clear_index_q;
          mem_write_data    = '0;
          clear_index_d     = clear_index_q + ADDRESS_WIDTH'(1);
          if (clear_index_q == LAST_INDEX) state_d = READY;
        end
        READY: begin
          mem_write_enable = user_write;
        end
        default: state_d = CLEAR;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    state_q       <= state_d;
    clear_index_q <= clear_index_d;
  end

  always_ff @(posedge clock) begin
    if (mem_write_enable && (mem_write_address != '0)) begin
      entries_q[mem_write_address] <= mem_write_data;
    end
  end

  assign busy = (state_q == CLEAR);

  always_comb begin
    register_file_read_value_1 = '0;
    if (state_q == READY && register_file_read_address_1 != '0) begin
      register_file_read_value_1 = entries_q[register_file_read_address_1];
`ifdef REGISTER_FILE_BYPASS_EN
      if (user_write && register_file_read_address_1 == register_file_write_address) begin
        register_file_read_value_1 = register_file_write_value;
      end
`endif
    end
  end

  always_comb begin
    register_file_read_value_2 = '0;
    if (state_q == READY && register_file_read_address_2 != '0) begin
      register_file_read_value_2 = entries_q[register_file_read_address_2];
`ifdef REGISTER_FILE_BYPASS_EN
      if (user_write && register_file_read_address_2 == register_file_write_address) begin
        register_file_read_value_2 = register_file_write_value;
      end
`endif
    end
  end

endmodule
